// File: rtl/dsp_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side
// valid/ready queue head. The master side is the fetch stage.
interface dsp_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/dsp_fetch.sv
// Instruction fetch stage: PC sequencing, synchronous imem reads, a 4-entry
// return queue toward decode, branch redirect flush and halt/drain control.
module dsp_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              halted,
    dsp_fetch_if.master       bus
);
    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               inflight_r;
    logic [INSTR_W-1:0] q_instr_r [4];
    logic [ADDR_W-1:0]  q_pc_r    [4];
    logic [1:0]         head_r;
    logic [1:0]         tail_r;
    logic [2:0]         count_r;
    logic [2:0]         occupancy_s;
    logic               issue_s;
    logic               push_s;
    logic               pop_s;

    // Issue/return/pop decisions and halt FSM next state.
    always_comb begin
        occupancy_s = count_r + {2'b00, inflight_r};
        issue_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        state_nxt_s = state_r;

        // Counting in-flight reads against free slots is what keeps the queue from overflowing.
        if (!rst && !halt && !jump_flag && (occupancy_s < 3'd4)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end

        if (inflight_r && !jump_flag) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        if ((count_r != 3'd0) && bus.instr_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        case (state_r)
            ST_RUN: begin
                if (halt && (count_r == 3'd0) && !inflight_r) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Halt FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC, in-flight tracking and return queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            head_r        <= 2'd0;
            tail_r        <= 2'd0;
            count_r       <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                q_instr_r[i] <= {INSTR_W{1'b0}};
                q_pc_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (jump_flag) begin
            // A redirect discards both queued words and the read still in flight.
            pc_r       <= jump_addr;
            inflight_r <= 1'b0;
            head_r     <= 2'd0;
            tail_r     <= 2'd0;
            count_r    <= 3'd0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r          <= pc_r + PC_STEP;
                inflight_pc_r <= pc_r;
            end
            if (push_s) begin
                q_instr_r[tail_r] <= bus.imem_rdata;
                q_pc_r[tail_r]    <= inflight_pc_r;
                tail_r            <= tail_r + 2'd1;
            end
            if (pop_s) begin
                head_r <= head_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.imem_en     = issue_s;
    assign bus.imem_addr   = pc_r;
    assign bus.instr       = q_instr_r[head_r];
    assign bus.instr_pc    = q_pc_r[head_r];
    assign bus.instr_valid = (count_r != 3'd0);
    assign halted          = (state_r == ST_HALTED);
endmodule

// File: tb/tb_dsp_fetch.sv
// Directed bench for dsp_fetch: reset, streaming, backpressure, redirect,
// PC wrap, halt drain, combined jump+halt and mid-run reset.
module tb_dsp_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [15:0] jump_addr;
    logic        halt;
    logic        halted;
    logic [15:0] exp_pc;
    int          compared   = 0;
    int          mismatched = 0;
    int          issues;

    dsp_fetch_if #(.ADDR_W(16), .INSTR_W(32)) bus ();

    dsp_fetch #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0010)) dut (
        .clk       (clk),
        .rst       (rst),
        .jump_flag (jump_flag),
        .jump_addr (jump_addr),
        .halt      (halt),
        .halted    (halted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory returning address-tagged words.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= {16'hBEEF, bus.imem_addr};
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; jump_flag = 1'b0; jump_addr = 16'h0000; halt = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (3) next_cycle();
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_en", 32'(bus.imem_en), 32'h0);
        chk("rst_addr", 32'(bus.imem_addr), 32'h0010);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", 32'(bus.instr_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Cycle 0: first fetch of RESET_PC
        rst = 1'b0;
        #1;
        chk("c0_en", 32'(bus.imem_en), 32'h1);
        chk("c0_addr", 32'(bus.imem_addr), 32'h0010);
        next_cycle(); #1;
        chk("c1_valid", 32'(bus.instr_valid), 32'h0);
        chk("c1_addr", 32'(bus.imem_addr), 32'h0011);
        next_cycle(); #1;
        chk("c2_valid", 32'(bus.instr_valid), 32'h1);
        chk("c2_pc", 32'(bus.instr_pc), 32'h0010);
        chk("c2_instr", bus.instr, 32'hBEEF0010);
        for (int k = 3; k <= 5; k++) begin
            next_cycle(); #1;
            exp_pc = 16'h000E + 16'(k);
            chk("stream_pc", 32'(bus.instr_pc), 32'(exp_pc));
            chk("stream_valid", 32'(bus.instr_valid), 32'h1);
        end

        // Cycle 6: branch to 0x0200
        next_cycle();
        jump_flag = 1'b1; jump_addr = 16'h0200;
        #1;
        chk("br_en", 32'(bus.imem_en), 32'h0);
        chk("br_head", 32'(bus.instr_pc), 32'h0014);
        next_cycle(); jump_flag = 1'b0; #1;
        chk("br7_valid", 32'(bus.instr_valid), 32'h0);
        chk("br7_addr", 32'(bus.imem_addr), 32'h0200);
        chk("br7_en", 32'(bus.imem_en), 32'h1);
        next_cycle(); #1;
        chk("br8_valid", 32'(bus.instr_valid), 32'h0);
        next_cycle(); #1;
        chk("br9_valid", 32'(bus.instr_valid), 32'h1);
        chk("br9_pc", 32'(bus.instr_pc), 32'h0200);
        chk("br9_instr", bus.instr, 32'hBEEF0200);
        next_cycle(); #1;
        chk("br10_pc", 32'(bus.instr_pc), 32'h0201);

        // Backpressure from a clean redirect to 0x0300
        next_cycle();
        jump_flag = 1'b1; jump_addr = 16'h0300; bus.instr_ready = 1'b0;
        issues = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle(); jump_flag = 1'b0; #1;
            if (bus.imem_en) issues++;
        end
        chk("bp_issues", 32'(issues), 32'd4);
        chk("bp_en_off", 32'(bus.imem_en), 32'h0);
        chk("bp_valid", 32'(bus.instr_valid), 32'h1);
        chk("bp_head", 32'(bus.instr_pc), 32'h0300);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            #1;
            exp_pc = 16'h0300 + 16'(i);
            chk("bp_drain_pc", 32'(bus.instr_pc), 32'(exp_pc));
            chk("bp_drain_valid", 32'(bus.instr_valid), 32'h1);
        end

        // PC wrap through 0xFFFF
        next_cycle();
        jump_flag = 1'b1; jump_addr = 16'hFFFE;
        next_cycle(); jump_flag = 1'b0; #1;
        chk("wr1_valid", 32'(bus.instr_valid), 32'h0);
        next_cycle(); #1;
        chk("wr2_valid", 32'(bus.instr_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); #1;
            exp_pc = 16'hFFFE + 16'(i);
            chk("wrap_pc", 32'(bus.instr_pc), 32'(exp_pc));
            chk("wrap_instr", bus.instr, {16'hBEEF, exp_pc});
        end

        // Halt with a full queue
        next_cycle();
        jump_flag = 1'b1; jump_addr = 16'h0400; bus.instr_ready = 1'b0;
        next_cycle(); jump_flag = 1'b0;
        repeat (5) next_cycle();
        halt = 1'b1; bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            #1;
            exp_pc = 16'h0400 + 16'(i);
            chk("ht_pc", 32'(bus.instr_pc), 32'(exp_pc));
            chk("ht_en", 32'(bus.imem_en), 32'h0);
            chk("ht_halted_lo", 32'(halted), 32'h0);
        end
        next_cycle(); #1;
        chk("ht_empty", 32'(bus.instr_valid), 32'h0);
        chk("ht_halted_wait", 32'(halted), 32'h0);
        next_cycle(); #1;
        chk("ht_halted", 32'(halted), 32'h1);
        next_cycle(); halt = 1'b0; #1;
        chk("ht_resume_en", 32'(bus.imem_en), 32'h1);
        chk("ht_resume_addr", 32'(bus.imem_addr), 32'h0404);
        next_cycle(); #1;
        chk("ht_run", 32'(halted), 32'h0);
        next_cycle(); #1;
        chk("ht_resume_pc", 32'(bus.instr_pc), 32'h0404);

        // Jump and halt in the same cycle
        next_cycle();
        jump_flag = 1'b1; jump_addr = 16'h0500; halt = 1'b1;
        #1;
        chk("jh_en0", 32'(bus.imem_en), 32'h0);
        next_cycle(); jump_flag = 1'b0; #1;
        chk("jh_en1", 32'(bus.imem_en), 32'h0);
        chk("jh_addr", 32'(bus.imem_addr), 32'h0500);
        chk("jh_valid", 32'(bus.instr_valid), 32'h0);
        next_cycle(); #1;
        chk("jh_halted", 32'(halted), 32'h1);
        chk("jh_en2", 32'(bus.imem_en), 32'h0);
        next_cycle(); halt = 1'b0; #1;
        chk("jh_resume_en", 32'(bus.imem_en), 32'h1);
        chk("jh_resume_addr", 32'(bus.imem_addr), 32'h0500);
        next_cycle(); next_cycle(); #1;
        chk("jh_pc", 32'(bus.instr_pc), 32'h0500);
        chk("jh_pc_valid", 32'(bus.instr_valid), 32'h1);

        // Mid-run reset with a partly filled queue
        next_cycle(); bus.instr_ready = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
        #1;
        chk("mr_en", 32'(bus.imem_en), 32'h0);
        next_cycle(); #1;
        chk("mr_valid", 32'(bus.instr_valid), 32'h0);
        chk("mr_addr", 32'(bus.imem_addr), 32'h0010);
        chk("mr_instr", bus.instr, 32'h0);
        chk("mr_pc", 32'(bus.instr_pc), 32'h0);
        chk("mr_halted", 32'(halted), 32'h0);
        rst = 1'b0; bus.instr_ready = 1'b1;
        #1;
        chk("mr_c0_en", 32'(bus.imem_en), 32'h1);
        next_cycle(); next_cycle(); #1;
        chk("mr_c2_pc", 32'(bus.instr_pc), 32'h0010);
        chk("mr_c2_instr", bus.instr, 32'hBEEF0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
